// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 VGA timing, VRAM scan addressing and RGB444 pin stage
module vga_scan_ctrl #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter logic [19:0] VRAM_BASE = 20'h00000
) (
    input  logic        clk_25mhz,
    input  logic        rst,
    input  logic        scan_en,
    output logic [19:0] vram_scan_addr,
    input  logic [15:0] vram_scan_data,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);
    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [18:0] PIX_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic [18:0] r_pix_idx;
    logic [19:0] r_addr;
    logic        r_en_q;
    logic [1:0]  r_act_d;
    logic [1:0]  r_hs_d;
    logic [1:0]  r_vs_d;
    logic [1:0]  r_fs_d;
    logic        r_hs;
    logic        r_vs;
    logic        r_fs;
    logic [11:0] r_rgb;

    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_hs_n;
    logic w_vs_n;
    logic w_frame;
    logic w_unused;

    assign w_h_last = r_h_cnt == H_LAST;
    assign w_v_last = r_v_cnt == V_LAST;
    assign w_active = r_h_cnt < H_ACT && r_v_cnt < V_ACT;
    assign w_hs_n   = !(r_h_cnt >= HS_BEG && r_h_cnt <= HS_END);
    assign w_vs_n   = !(r_v_cnt >= VS_BEG && r_v_cnt <= VS_END);
    assign w_frame  = r_h_cnt == 10'd0 && r_v_cnt == 10'd0;
    assign w_unused = ^{vram_scan_data[11], vram_scan_data[6:5], vram_scan_data[0]};

    assign vram_scan_addr = r_addr;
    assign vga_hs         = r_hs;
    assign vga_vs         = r_vs;
    assign {vga_r, vga_g, vga_b} = r_rgb;
    assign frame_start    = r_fs;

    // Horizontal and vertical scan counters; v advances on h wrap, both wrap together at frame end
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 10'd1;
            if (w_h_last)
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
        end
    end

    // Pixel index, registered VRAM address (moves only on active pixels) and frame-start enable latch
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_pix_idx <= '0;
            r_addr    <= VRAM_BASE;
            r_en_q    <= 1'b0;
        end else begin
            r_pix_idx <= (w_h_last && w_v_last) ? '0 :
                         (w_active && r_pix_idx != PIX_LAST) ? r_pix_idx + 19'd1 : r_pix_idx;
            if (w_active)
                r_addr <= VRAM_BASE + {1'b0, r_pix_idx};
            if (w_frame)
                r_en_q <= scan_en;
        end
    end

    // Delay region flags through the address and SRAM stages, then register pins with gated colour
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            r_act_d <= '0;
            r_hs_d  <= 2'b11;
            r_vs_d  <= 2'b11;
            r_fs_d  <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_fs    <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_act_d <= {r_act_d[0], w_active};
            r_hs_d  <= {r_hs_d[0], w_hs_n};
            r_vs_d  <= {r_vs_d[0], w_vs_n};
            r_fs_d  <= {r_fs_d[0], w_frame};
            r_hs    <= r_hs_d[1];
            r_vs    <= r_vs_d[1];
            r_fs    <= r_fs_d[1];
            r_rgb   <= (r_act_d[1] && r_en_q) ?
                       {vram_scan_data[15:12], vram_scan_data[10:7], vram_scan_data[4:1]} : '0;
        end
    end
endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed checks of sync timing, addressing, colour gating and reset
module tb_vga_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en;
    logic        mode;
    logic [19:0] addr;
    logic [15:0] data = 16'h0000;
    logic        hs, vs, fs;
    logic [3:0]  r, g, b;
    logic [11:0] rgb;

    int n_tests = 0, n_fail = 0;
    int k = 0;
    int hs_low = 0, hs_fall = 0, vs_low = 0, fs_cnt = 0;
    int nz_blank = 0, good_act = 0, nz_all = 0;
    logic hs_prev = 1'b1;

    assign rgb = {r, g, b};

    vga_scan_ctrl #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .VRAM_BASE(20'h10000)
    ) dut (
        .clk_25mhz(clk), .rst(rst), .scan_en(scan_en),
        .vram_scan_addr(addr), .vram_scan_data(data),
        .vga_hs(hs), .vga_vs(vs), .vga_r(r), .vga_g(g), .vga_b(b),
        .frame_start(fs)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) data <= mode ? 16'hF81F : addr[15:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int c, ph, pv;
        logic pact;
        @(posedge clk);
        #1;
        k++;
        if (!hs) hs_low++;
        if (hs_prev && !hs && hs_fall == 0) hs_fall = k;
        hs_prev = hs;
        if (!vs) vs_low++;
        if (fs) fs_cnt++;
        if (rgb != 12'h000) nz_all++;
        c = k - 3;
        if (c >= 0) begin
            ph = c % 800;
            pv = (c / 800) % 10;
            pact = ph < 640 && pv < 4;
            if (!pact && rgb != 12'h000) nz_blank++;
            if (pact && rgb == 12'hF0F) good_act++;
        end
    endtask

    task automatic run_to(input int n);
        while (k < n) step();
    endtask

    initial begin
        rst = 1'b1;
        scan_en = 1'b1;
        mode = 1'b0;
        step();
        step();
        check("rst_hs", 32'(hs), 32'h1);
        check("rst_vs", 32'(vs), 32'h1);
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_fs", 32'(fs), 32'h0);
        check("rst_addr", 32'(addr), 32'h10000);
        rst = 1'b0;
        k = 0;
        run_to(1);    check("addr_px0", 32'(addr), 32'h10000);
        run_to(3);    check("fs_px0", 32'(fs), 32'h1);
                      check("rgb_px0", 32'(rgb), 32'h000);
        run_to(4);    check("fs_off", 32'(fs), 32'h0);
        run_to(642);  check("rgb_px639", 32'(rgb), 32'h04F);
        run_to(800);  check("hs_low_line", 32'(hs_low), 32'd96);
                      check("hs_fall", 32'(hs_fall), 32'd659);
        run_to(801);  check("addr_line1", 32'(addr), 32'h10280);
        run_to(803);  check("rgb_line1", 32'(rgb), 32'h050);
        run_to(1458); check("hs_pre_fall2", 32'(hs), 32'h1);
        run_to(1459); check("hs_fall2", 32'(hs), 32'h0);
        run_to(3040); check("addr_last", 32'(addr), 32'h109FF);
        run_to(7999); check("addr_hold", 32'(addr), 32'h109FF);
        run_to(8000); check("vs_low_frame1", 32'(vs_low), 32'd1600);
        vs_low = 0;
        mode = 1'b1;
        run_to(8001); check("addr_frame2", 32'(addr), 32'h10000);
        run_to(8002); check("blank_frame1", 32'(nz_blank), 32'd0);
        good_act = 0;
        run_to(8003); check("fs_frame2", 32'(fs), 32'h1);
                      check("rgb_f81f", 32'(rgb), 32'hF0F);
        run_to(8800);
        scan_en = 1'b0;
        run_to(10503); check("rgb_after_drop", 32'(rgb), 32'hF0F);
        run_to(16000);
        vs_low = 0;
        run_to(16002); check("active_frame2", 32'(good_act), 32'd2560);
                       check("blank_frame2", 32'(nz_blank), 32'd0);
        nz_all = 0;
        run_to(16003); check("fs_frame3", 32'(fs), 32'h1);
        run_to(16659); check("hs_frame3", 32'(hs), 32'h0);
        run_to(24000); check("vs_low_frame3", 32'(vs_low), 32'd1600);
        run_to(24002); check("rgb_disabled", 32'(nz_all), 32'd0);
                       check("fs_count", 32'(fs_cnt), 32'd3);
        run_to(30300); check("vs_in_sync", 32'(vs), 32'h0);
                       check("hs_in_sync", 32'(hs), 32'h0);
        rst = 1'b1;
        step();
        check("mid_rst_hs", 32'(hs), 32'h1);
        check("mid_rst_vs", 32'(vs), 32'h1);
        check("mid_rst_rgb", 32'(rgb), 32'h0);
        check("mid_rst_fs", 32'(fs), 32'h0);
        check("mid_rst_addr", 32'(addr), 32'h10000);
        rst = 1'b0;
        k = 0;
        hs_fall = 0;
        run_to(1);   check("vs_clean1", 32'(vs), 32'h1);
        run_to(2);   check("vs_clean2", 32'(vs), 32'h1);
        run_to(3);   check("fs_after_rst", 32'(fs), 32'h1);
        run_to(700); check("hs_fall_after_rst", 32'(hs_fall), 32'd659);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
